// File: rtl/alu.sv
// Signed BW-bit ALU: result plus {overflow, negative, zero} flags, captured on the clock edge (1-cycle latency).
// Accepts one operation every cycle; no backpressure. Synchronous active-low reset loads out=0, flags=3'b001.
module alu #(
   parameter int BW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [BW-1:0] in_a,
   input  logic [BW-1:0] in_b,
   input  logic [3:0]    opcode,
   output logic [BW-1:0] out,
   output logic [2:0]    flags
);

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_AND  = 4'b0010;
   localparam logic [3:0] OP_OR   = 4'b0011;
   localparam logic [3:0] OP_XOR  = 4'b0100;
   localparam logic [3:0] OP_INC  = 4'b0101;
   localparam logic [3:0] OP_MOVA = 4'b0110;
   localparam logic [3:0] OP_MOVB = 4'b0111;

   logic [BW:0]   a_ext;
   logic [BW:0]   b_ext;
   logic [BW:0]   exact;
   logic          is_arith;
   logic [BW-1:0] res;
   logic          ovf;
   logic          neg;

   logic [BW-1:0] out_d, out_q;
   logic [2:0]    flags_d, flags_q;

   always_comb begin
      a_ext    = {in_a[BW-1], in_a};
      b_ext    = {in_b[BW-1], in_b};
      exact    = '0;
      is_arith = 1'b0;
      res      = '0;
      case (opcode)
         OP_ADD: begin
            exact    = a_ext + b_ext;
            is_arith = 1'b1;
         end
         OP_SUB: begin
            exact    = a_ext - b_ext;
            is_arith = 1'b1;
         end
         OP_INC: begin
            exact    = a_ext + {{BW{1'b0}}, 1'b1};
            is_arith = 1'b1;
         end
         OP_AND:  res = in_a & in_b;
         OP_OR:   res = in_a | in_b;
         OP_XOR:  res = in_a ^ in_b;
         OP_MOVA: res = in_a;
         OP_MOVB: res = in_b;
         default: res = '0;
      endcase

      // The exact BW+1-bit result always fits; overflow means it cannot be narrowed to BW bits.
      if (is_arith) begin
         res = exact[BW-1:0];
         ovf = exact[BW] ^ exact[BW-1];
         neg = exact[BW];
      end else begin
         ovf = 1'b0;
         neg = res[BW-1];
      end

      out_d   = res;
      flags_d = {ovf, neg, ~|res};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_q   <= '0;
         flags_q <= 3'b001;
      end else begin
         out_q   <= out_d;
         flags_q <= flags_d;
      end
   end

   assign out   = out_q;
   assign flags = flags_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed flag/overflow cases plus random back-to-back ops against an integer model.
module tb_alu;

   localparam int BW = 16;

   logic          clk;
   logic          rst_n;
   logic [BW-1:0] in_a;
   logic [BW-1:0] in_b;
   logic [3:0]    opcode;
   logic [BW-1:0] out;
   logic [2:0]    flags;

   int tests;
   int fails;
   logic [18:0] sb[$];

   alu #(.BW(BW)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .in_a   (in_a),
      .in_b   (in_b),
      .opcode (opcode),
      .out    (out),
      .flags  (flags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: integer arithmetic, so overflow/sign come from true values rather than bit tricks.
   function automatic logic [18:0] model(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op);
      int sa, sbv, ex;
      logic [15:0] r;
      logic o, n;
      bit arith;
      sa = $signed(a);
      sbv = $signed(b);
      ex = 0;
      arith = 1'b1;
      case (op)
         4'd0: ex = sa + sbv;
         4'd1: ex = sa - sbv;
         4'd5: ex = sa + 1;
         default: arith = 1'b0;
      endcase
      if (arith) begin
         r = ex[15:0];
         o = (ex > 32767) || (ex < -32768);
         n = (ex < 0);
      end else begin
         case (op)
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd6: r = a;
            4'd7: r = b;
            default: r = 16'h0000;
         endcase
         o = 1'b0;
         n = r[15];
      end
      return {r, o, n, (r == 16'h0000)};
   endfunction

   task automatic step(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op);
      in_a = a;
      in_b = b;
      opcode = op;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      logic [18:0] exp;
      rst_n = 1'b0;
      sb.push_back({16'h0000, 3'b001});
      step(16'h1234, 16'h0001, 4'b0000);
      exp = sb.pop_front();
      tests++;
      if ({out, flags} !== exp) begin
         fails++;
         $display("FAIL reset got out=%h flags=%b want out=%h flags=%b", out, flags, exp[18:3], exp[2:0]);
      end
      rst_n = 1'b1;
      sb.push_back({16'h1235, 3'b000});
      step(16'h1234, 16'h0001, 4'b0000);
      exp = sb.pop_front();
      tests++;
      if ({out, flags} !== exp) begin
         fails++;
         $display("FAIL reset_release got out=%h flags=%b want out=%h flags=%b", out, flags, exp[18:3], exp[2:0]);
      end
   endtask

   task automatic test_directed;
      logic [15:0] ta[14] = '{16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, 16'h0005, 16'h7FFF, 16'hFFFF,
                              16'h0010, 16'hF0F0, 16'h00F0, 16'hAAAA, 16'h8001, 16'h1234, 16'h5555};
      logic [15:0] tb_[14] = '{16'h7FFF, 16'h8000, 16'h8000, 16'h7FFF, 16'h0005, 16'h1111, 16'h2222,
                               16'h3333, 16'h8F00, 16'h0F00, 16'hAAAA, 16'h4444, 16'h0000, 16'h6666};
      logic [3:0]  to[14] = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd5, 4'd5,
                              4'd5, 4'd2, 4'd3, 4'd4, 4'd6, 4'd7, 4'b1010};
      logic [18:0] te[14] = '{{16'hFFFE, 3'b100}, {16'h0000, 3'b111}, {16'hFFFF, 3'b100}, {16'h0001, 3'b110},
                              {16'h0000, 3'b001}, {16'h8000, 3'b100}, {16'h0000, 3'b001}, {16'h0011, 3'b000},
                              {16'h8000, 3'b010}, {16'h0FF0, 3'b000}, {16'h0000, 3'b001}, {16'h8001, 3'b010},
                              {16'h0000, 3'b001}, {16'h0000, 3'b001}};
      logic [18:0] exp;
      for (int i = 0; i < 14; i++) begin
         sb.push_back(te[i]);
         step(ta[i], tb_[i], to[i]);
         exp = sb.pop_front();
         tests++;
         if ({out, flags} !== exp) begin
            fails++;
            $display("FAIL directed[%0d] op=%b got out=%h flags=%b want out=%h flags=%b",
                     i, to[i], out, flags, exp[18:3], exp[2:0]);
         end
      end
   endtask

   task automatic test_back_to_back;
      logic [18:0] exp;
      logic [15:0] a, b;
      for (int op = 0; op < 16; op++) begin
         for (int k = 0; k < 6; k++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            if (k == 0) a = 16'h8000;
            if (k == 1) b = 16'h7FFF;
            sb.push_back(model(a, b, 4'(op)));
            step(a, b, 4'(op));
            exp = sb.pop_front();
            tests++;
            if ({out, flags} !== exp) begin
               fails++;
               $display("FAIL random op=%0d a=%h b=%h got out=%h flags=%b want out=%h flags=%b",
                        op, a, b, out, flags, exp[18:3], exp[2:0]);
            end
         end
      end
   endtask

   task automatic test_reset_midstream;
      logic [18:0] exp;
      rst_n = 1'b0;
      sb.push_back({16'h0000, 3'b001});
      step(16'h7FFF, 16'h7FFF, 4'd0);
      exp = sb.pop_front();
      tests++;
      if ({out, flags} !== exp) begin
         fails++;
         $display("FAIL reset_mid got out=%h flags=%b want out=%h flags=%b", out, flags, exp[18:3], exp[2:0]);
      end
      rst_n = 1'b1;
      sb.push_back({16'h8007, 3'b010});
      step(16'h1111, 16'h8007, 4'd7);
      exp = sb.pop_front();
      tests++;
      if ({out, flags} !== exp) begin
         fails++;
         $display("FAIL reset_mid_release got out=%h flags=%b want out=%h flags=%b", out, flags, exp[18:3], exp[2:0]);
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      rst_n = 1'b0;
      in_a = '0;
      in_b = '0;
      opcode = '0;
      @(negedge clk);
      test_reset();
      test_directed();
      test_back_to_back();
      test_reset_midstream();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/alu.md
# alu

Parameterizable signed integer ALU with registered outputs, used as the arithmetic/logic execution unit of the datapath. It takes two BW-bit two's-complement operands and a 4-bit opcode. It produces a BW-bit result plus a 3-bit status vector {overflow, negative, zero}. Result and flags are captured on the clock edge, giving one cycle of latency.

## Interface
- BW, 16, operand/result bit width in bits (BW ≥ 2).

- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- in_a  input  BW  operand A, signed two's complement.
- in_b  input  BW  operand B, signed two's complement.
- opcode  input  4  operation select.
- out  output  BW  registered result, signed.
- flags  output  3  registered status: flags[2]=overflow, flags[1]=negative, flags[0]=zero.

## Operation
- Opcodes, with result before registering:
  - 0000 ADD: in_a + in_b
  - 0001 SUB: in_a − in_b
  - 0010 AND: in_a & in_b
  - 0011 OR: in_a | in_b
  - 0100 XOR: in_a ^ in_b
  - 0101 INC: in_a + 1
  - 0110 MOVA: in_a
  - 0111 MOVB: in_b
  - 1000–1111: reserved; result is 0, flags = 3'b001.
- Arithmetic (ADD, SUB, INC):
  - Compute the exact (BW+1)-bit signed result from sign-extended operands.
  - out = low BW bits of the exact result (wrap-around).
  - overflow = 1 when the exact result is outside [−2^(BW−1), 2^(BW−1)−1].
  - negative = bit BW (true sign) of the exact result, not out[BW−1].
  - Consequence: {negative, out} always equals the exact BW+1-bit result, including on overflow.
- Logic and move ops (AND, OR, XOR, MOVA, MOVB):
  - overflow = 0.
  - negative = out[BW−1].
- zero = 1 when the BW-bit out is all zeros, for every opcode, even if the exact result is non-zero.
- in_b is ignored for INC and MOVA; in_a is ignored for MOVB.

## Timing
- Combinational result/flag logic feeds a BW+3-bit output register.
- Latency 1 cycle: inputs present before rising edge N appear on out/flags after edge N. The register holds until the next edge.
- No handshake; a new operation is accepted every cycle (throughput 1 per clock).
- Reset: when rst_n=0 at a rising edge, out←0 and flags←3'b001, taking priority over any operation. The reset values are internally consistent (zero flag set for a zero result).
- Reset mid-stream: the in-flight result is discarded. The first result after reset deasserts reflects the inputs at the first edge with rst_n=1.
- Outputs are never X after the first reset edge; unknown/reserved opcodes follow the reserved rule.

## Test plan
- Reset: rst_n=0 for one edge with in_a=0x1234, opcode=ADD → out=0x0000, flags=3'b001. Release; the next edge gives out=0x1234+in_b.
- ADD overflow: 0x7FFF+0x7FFF → out=0xFFFE, flags=3'b100. 0x8000+0x8000 → out=0x0000, flags=3'b111 ({neg,out} = −65536).
- SUB overflow: 0x7FFF−0x8000 → out=0xFFFF, flags=3'b100. 0x8000−0x7FFF → out=0x0001, flags=3'b110. 5−5 → out=0, flags=3'b001.
- INC: 0x7FFF → out=0x8000, flags=3'b100. 0xFFFF → out=0x0000, flags=3'b001. 0x0010 → out=0x0011, flags=3'b000.
- Logic/move:
  - AND 0xF0F0,0x8F00 → 0x8000, flags=3'b010.
  - OR 0x00F0,0x0F00 → 0x0FF0, flags=3'b000.
  - XOR 0xAAAA,0xAAAA → 0x0000, flags=3'b001.
  - MOVA 0x8001 → 0x8001, flags=3'b010.
  - MOVB (in_b=0) → 0, flags=3'b001.
- Random plus reserved: ≥5 random operand pairs per opcode, checked against the exact model for {negative,out} and each flag, at one-cycle latency with back-to-back opcodes. Opcode 4'b1010 → out=0, flags=3'b001.
